poly_horner_sequencer: RTL and testbench



---
 rtl/poly_horner_pkg.sv | 22 ++
 rtl/horner_mac_step.sv | 19 +
 rtl/poly_horner_sequencer.sv | 118 +++++++++++
 tb/tb_poly_horner_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/poly_horner_pkg.sv
// Shared types and fixed-point helpers for the Horner exp(x) sequencer.
// Input/coefficients are unsigned Q2.14, the accumulator is unsigned Q7.25.
package poly_horner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam int FRAC_IN     = 14;
    localparam int FRAC_OUT    = 25;
    localparam int ALIGN_SHIFT = FRAC_OUT - FRAC_IN;
    localparam int STEPS       = 5;

    function automatic logic [31:0] align(input logic [15:0] c);
        logic [31:0] r;
        r = 32'(c) << ALIGN_SHIFT;
        return r;
    endfunction

endpackage

// File: rtl/horner_mac_step.sv
// One Horner step: acc_next = trunc((acc * x) >> FRAC_IN) + align(coef), modulo 2^32.
module horner_mac_step
    import poly_horner_pkg::*;
(
    input  logic [31:0] acc,
    input  logic [15:0] x,
    input  logic [15:0] coef,
    output logic [31:0] acc_next
);

    logic [47:0] prod_s;

    // Shared multiplier and adder; the Q2.14 scaling of x is dropped by truncation.
    always_comb begin
        prod_s   = 48'(acc) * 48'(x);
        acc_next = prod_s[FRAC_IN +: 32] + align(coef);
    end

endmodule

// File: rtl/poly_horner_sequencer.sv
// Sequential 5th-order Taylor exp(x) evaluator, one Horner step per cycle,
// valid/ready on input and output; the result is held until consumed.
module poly_horner_sequencer
    import poly_horner_pkg::*;
#(
    parameter int          WIDTHIN  = 16,
    parameter int          WIDTHOUT = 32,
    parameter logic [15:0] A0       = 16'h4000,
    parameter logic [15:0] A1       = 16'h4000,
    parameter logic [15:0] A2       = 16'h2000,
    parameter logic [15:0] A3       = 16'h0AAA,
    parameter logic [15:0] A4       = 16'h02AA,
    parameter logic [15:0] A5       = 16'h0088
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [WIDTHIN-1:0]  i_x,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [WIDTHOUT-1:0] o_y,
    output logic                o_busy,
    output logic [2:0]          o_step
);

    state_t      state_q, state_d;
    logic [15:0] x_q, x_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] y_q, y_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] coef_s;
    logic [31:0] acc_next_s;

    // Coefficient ROM indexed by the step counter; out-of-range falls back to A0.
    always_comb begin
        case (cnt_q)
            3'd4:    coef_s = A4;
            3'd3:    coef_s = A3;
            3'd2:    coef_s = A2;
            3'd1:    coef_s = A1;
            3'd0:    coef_s = A0;
            default: coef_s = A0;
        endcase
    end

    horner_mac_step u_mac (
        .acc      (acc_q),
        .x        (x_q),
        .coef     (coef_s),
        .acc_next (acc_next_s)
    );

    // Next-state and datapath update; the result register loads on the last step.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        acc_d   = acc_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    x_d     = i_x;
                    acc_d   = align(A5);
                    cnt_d   = 3'(STEPS - 1);
                    state_d = ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                acc_d = acc_next_s;
                if (cnt_q == 3'd0) begin
                    y_d     = acc_next_s;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_DONE: begin
                if (i_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            x_q     <= 16'h0000;
            acc_q   <= 32'h0000_0000;
            y_q     <= 32'h0000_0000;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
        end
    end

    // Status outputs decode registered state only, so they are mutually exclusive.
    always_comb begin
        o_ready = (state_q == ST_IDLE);
        o_busy  = (state_q == ST_CALC);
        o_valid = (state_q == ST_DONE);
        o_y     = y_q;
        o_step  = cnt_q;
    end

endmodule

// File: tb/tb_poly_horner_sequencer.sv
// Directed self-checking bench for poly_horner_sequencer.
module tb_poly_horner_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_valid;
    logic        o_ready;
    logic [15:0] i_x;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_y;
    logic        o_busy;
    logic [2:0]  o_step;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    poly_horner_sequencer dut (
        .clk     (clk),
        .reset   (reset),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_x     (i_x),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_y     (o_y),
        .o_busy  (o_busy),
        .o_step  (o_step)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; i_valid = 1'b0; i_x = 16'h0000; i_ready = 1'b1;
        tick(); tick();
        reset = 1'b0;
        checks++;
        if ({o_ready, o_valid, o_busy} !== 3'b100) begin
            errors++; $display("FAIL reset_flags got=%b want=100", {o_ready, o_valid, o_busy});
        end
        checks++;
        if (o_y !== 32'h0000_0000 || o_step !== 3'd0) begin
            errors++; $display("FAIL reset_regs got y=%h step=%0d want y=0 step=0", o_y, o_step);
        end
    endtask

    // Accept one x with i_ready high; check latency, pulse width and result.
    task automatic test_eval(input logic [15:0] x, input logic [31:0] exp_y, input string name);
        int n;
        i_ready = 1'b1;
        checks++;
        if (o_ready !== 1'b1) begin
            errors++; $display("FAIL %s_ready_before got=%b want=1", name, o_ready);
        end
        i_valid = 1'b1; i_x = x;
        tick();
        i_valid = 1'b0; i_x = 16'hFFFF;
        checks++;
        if (o_busy !== 1'b1 || o_step !== 3'd4 || o_ready !== 1'b0) begin
            errors++; $display("FAIL %s_calc_entry got busy=%b step=%0d ready=%b want 1 4 0",
                               name, o_busy, o_step, o_ready);
        end
        n = 1;
        while (o_valid !== 1'b1 && n < 20) begin
            tick(); n++;
        end
        checks++;
        if (n !== 6) begin
            errors++; $display("FAIL %s_latency got=%0d want=6", name, n);
        end
        checks++;
        if (o_y !== exp_y) begin
            errors++; $display("FAIL %s_value got=%h want=%h", name, o_y, exp_y);
        end
        tick();
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            errors++; $display("FAIL %s_pulse got valid=%b ready=%b want 0 1", name, o_valid, o_ready);
        end
    endtask

    task automatic test_backpressure();
        int n;
        int bad;
        i_ready = 1'b0;
        i_valid = 1'b1; i_x = 16'h4000;
        tick();
        i_valid = 1'b0;
        n = 1;
        while (o_valid !== 1'b1 && n < 20) begin
            tick(); n++;
        end
        checks++;
        if (n !== 6) begin
            errors++; $display("FAIL bp_latency got=%0d want=6", n);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            i_valid = i[0]; i_x = (i[1]) ? 16'h8000 : 16'h1234;
            tick();
            if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_busy !== 1'b0 || o_y !== 32'h056E_E000) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL bp_hold bad_cycles=%0d want=0 (last y=%h valid=%b ready=%b)",
                               bad, o_y, o_valid, o_ready);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        tick();
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release got valid=%b ready=%b want 0 1", o_valid, o_ready);
        end
    endtask

    task automatic test_reset_mid_calc();
        i_ready = 1'b1;
        i_valid = 1'b1; i_x = 16'h8000;
        tick();
        i_valid = 1'b0;
        tick(); tick();
        checks++;
        if (o_busy !== 1'b1 || o_step !== 3'd2) begin
            errors++; $display("FAIL midreset_pre got busy=%b step=%0d want 1 2", o_busy, o_step);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({o_ready, o_valid, o_busy} !== 3'b100 || o_y !== 32'h0000_0000 || o_step !== 3'd0) begin
            errors++; $display("FAIL midreset_state got flags=%b y=%h step=%0d want 100 0 0",
                               {o_ready, o_valid, o_busy}, o_y, o_step);
        end
        test_eval(16'h0000, 32'h0200_0000, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [15:0] xs [3];
        logic [31:0] ys [3];
        int acc_t [3];
        logic [31:0] res [3];
        int nacc;
        int nres;
        logic pre_ready;
        logic pre_valid;
        logic [31:0] pre_y;
        xs[0] = 16'h0000; xs[1] = 16'h4000; xs[2] = 16'h8000;
        ys[0] = 32'h0200_0000; ys[1] = 32'h056E_E000; ys[2] = 32'h0E87_8000;
        nacc = 0; nres = 0;
        i_ready = 1'b1; i_valid = 1'b1; i_x = xs[0];
        for (int c = 0; c < 60 && nres < 3; c++) begin
            pre_ready = o_ready; pre_valid = o_valid; pre_y = o_y;
            tick();
            if (pre_ready && i_valid) begin
                acc_t[nacc] = cyc; nacc++;
                if (nacc < 3) i_x = xs[nacc];
                else i_valid = 1'b0;
            end
            if (pre_valid) begin
                res[nres] = pre_y; nres++;
            end
        end
        i_valid = 1'b0;
        checks++;
        if (nres !== 3 || nacc !== 3) begin
            errors++; $display("FAIL b2b_count got acc=%0d res=%0d want 3 3", nacc, nres);
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (res[k] !== ys[k]) begin
                    errors++; $display("FAIL b2b_value%0d got=%h want=%h", k, res[k], ys[k]);
                end
            end
            checks++;
            if (acc_t[1] - acc_t[0] !== 7 || acc_t[2] - acc_t[1] !== 7) begin
                errors++; $display("FAIL b2b_spacing got=%0d,%0d want=7,7",
                                   acc_t[1] - acc_t[0], acc_t[2] - acc_t[1]);
            end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_eval(16'h0000, 32'h0200_0000, "x0");
        test_eval(16'h4000, 32'h056E_E000, "x1");
        test_eval(16'h8000, 32'h0E87_8000, "x2");
        test_backpressure();
        test_reset_mid_calc();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
